// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle control sequencer for the RV32IM datapath.
//               Steps each instruction FETCH -> DECODE -> EXEC/WAIT_M -> WB,
//               gates PC advance, IR load and register-file write, stalls on
//               M-extension ops with a watchdog, and counts retired
//               instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,   // max WAIT_M cycles before error (2..255)
    parameter int CNT_W          = 32    // retired-instruction counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic             dec_regwen,
    input  logic             alu_done,
    output logic             pc_en,
    output logic             ir_load,
    output logic             alu_start,
    output logic             rf_we,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_wait_m = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_err    = 3'd6;

    localparam logic [6:0]        c_op_reg    = 7'b0110011;
    localparam logic [6:0]        c_f7_mext   = 7'b0000001;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              w_is_mop;

    assign w_is_mop = (opcode == c_op_reg) && (funct7 == c_f7_mext);

    // State register; reset dominates everything, including a pending alu_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; alu_done is only honoured in WAIT_M and beats the watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   w_next = run ? c_st_fetch : c_st_idle;
            c_st_fetch:  w_next = c_st_decode;
            c_st_decode: w_next = w_is_mop ? c_st_wait_m : c_st_exec;
            c_st_exec:   w_next = c_st_wb;
            c_st_wait_m: begin
                if (alu_done) begin
                    w_next = c_st_wb;
                end else if (r_wait == c_wait_last) begin
                    w_next = c_st_err;
                end
            end
            c_st_wb:     w_next = run ? c_st_fetch : c_st_idle;
            c_st_err:    w_next = c_st_err;
            default:     w_next = c_st_idle;
        endcase
    end

    // Wait counter: zero whenever outside WAIT_M, so every entry starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (r_state == c_st_wait_m) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Retired counter bumps once per WB and wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_state == c_st_wb) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // Moore output decode; rf_we is the only output that looks at an input.
    always_comb begin
        pc_en       = 1'b0;
        ir_load     = 1'b0;
        alu_start   = 1'b0;
        rf_we       = 1'b0;
        busy        = (r_state != c_st_idle) && (r_state != c_st_err);
        timeout_err = (r_state == c_st_err);
        case (r_state)
            c_st_fetch:  ir_load   = 1'b1;
            c_st_wait_m: alu_start = (r_wait == '0);
            c_st_wb: begin
                pc_en = 1'b1;
                rf_we = dec_regwen;
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle control sequencer for the RV32IM datapath. Steps each instruction through fetch, decode, execute and writeback, and gates PC advance, instruction-register load and register-file write. Stalls on long-latency M-extension operations via a start/done handshake with the ALU, with a watchdog timeout. Counts retired instructions for debug/perf.

Parameters:
TIMEOUT_CYCLES, 64, max cycles allowed in WAIT_M before error (legal range 2..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  reset
run  input  1  enable sequencing; sampled in IDLE and WB
opcode  input  7  ins[6:0] of current instruction
funct7  input  7  ins[31:25] of current instruction
dec_regwen  input  1  register write enable from control logic decode
alu_done  input  1  multi-cycle ALU result valid (one-cycle pulse)
pc_en  output  1  PC advances to PC+1 at next edge
ir_load  output  1  instruction register / fetch capture
alu_start  output  1  launch multi-cycle ALU op (one-cycle pulse)
rf_we  output  1  gated register-file write enable
busy  output  1  high in every state except IDLE and ERR
timeout_err  output  1  sticky watchdog error flag
state  output  3  current state encoding
retired  output  CNT_W  retired-instruction count

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state=IDLE, wait counter=0, retired=0, timeout_err=0; all other outputs 0. rst wins over every other event, including mid-WAIT_M (pending alu_done after reset is ignored).
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT_M=4, WB=5, ERR=6; 7 unreachable -> IDLE next cycle.
- M-op detect (DECODE only): opcode==7'b0110011 && funct7==7'b0000001.
- Transitions:
  - IDLE: run=1 -> FETCH, else stay.
  - FETCH: ir_load=1 -> DECODE.
  - DECODE: M-op -> WAIT_M; else -> EXEC.
  - EXEC: -> WB (single cycle).
  - WAIT_M: alu_done=1 -> WB; else if wait count==TIMEOUT_CYCLES-1 -> ERR; else stay, count+1.
  - WB: rf_we=dec_regwen, pc_en=1, retired+1; run=1 -> FETCH, run=0 -> IDLE.
  - ERR: terminal until rst; timeout_err=1; pc_en/ir_load/alu_start/rf_we=0.
- Outputs are Moore (decoded from state register and wait counter); no combinational input->output path except rf_we = (state==WB) & dec_regwen.
- alu_start = 1 only in first WAIT_M cycle (wait count==0); wait count cleared on every entry to WAIT_M.
- alu_done outside WAIT_M ignored. alu_done in same cycle as timeout limit: done wins -> WB, no error.
- alu_done in first WAIT_M cycle (same cycle as alu_start) accepted -> WB.
- Latency: non-M instruction = 4 cycles FETCH->WB; M-op = 3 + N cycles, N = WAIT_M cycles (1..TIMEOUT_CYCLES).
- retired wraps modulo 2^CNT_W without flag.
- run deassertion mid-instruction does not abort; takes effect at WB.
- Counter width: ceil(log2(TIMEOUT_CYCLES)).

Test Plan:
- Reset then run=1, ADD (opcode 0110011, funct7 0000000), dec_regwen=1 -> states 1,2,3,5; rf_we and pc_en high in cycle 4 only; retired=1.
- MUL (funct7 0000001), alu_done 5 cycles after alu_start -> alu_start one pulse, WAIT_M for 6 cycles, WB once, rf_we=1, total 9 cycles.
- MUL with alu_done never asserted, TIMEOUT_CYCLES=8 -> ERR after 8 WAIT_M cycles, timeout_err=1 sticky, pc_en=0 thereafter until rst.
- alu_done at exactly 8th WAIT_M cycle (TIMEOUT_CYCLES=8) -> WB, timeout_err stays 0; stray alu_done in EXEC ignored.
- run dropped during EXEC -> WB completes, retired increments, then IDLE, busy=0; rst asserted during WAIT_M -> IDLE next cycle, retired=0.
- CNT_W=4, 17 back-to-back non-M instructions -> retired wraps 15->0->1.
